// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types, sizing functions and GF(2^8) helper for the AES key schedule
package aes_pkg;

    typedef logic [31:0]      aes_word_t;
    typedef logic [15:0][7:0] aes_rk_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GEN,
        ST_HOLD
    } aes_state_t;

    function automatic int nk(input int key_bits);
        return key_bits / 32;
    endfunction

    function automatic int nr(input int key_bits);
        return key_bits / 32 + 6;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box, one byte
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte, so the LSB offset of entry n is 8*(255-n).
    logic [10:0] w_lsb;
    assign w_lsb  = {~i_byte, 3'b000};
    assign o_byte = SBOX[w_lsb +: 8];

endmodule

// File: rtl/aes_key_schedule.sv
// rtl/aes_key_schedule.sv - iterative AES-128/192/256 key expansion, one word per cycle,
// round keys handed out on a valid/ready stream.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key,
    output logic                busy,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [127:0]        rk,
    output logic [3:0]          rk_index,
    output logic                done
);

    localparam int NK = nk(KEY_BITS);
    localparam int NR = nr(KEY_BITS);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_key_schedule: KEY_BITS must be 128, 192 or 256");
    end

    aes_state_t r_state, w_next;
    aes_word_t  r_win [NK];
    aes_rk_t    r_asm;
    logic [5:0] r_i;
    logic [2:0] r_imod;
    logic [7:0] r_rcon;
    logic [3:0] r_round;
    logic       r_done;

    aes_word_t w_temp, w_sub_in, w_sub_out, w_mixed, w_word;
    logic      w_expand, w_rot_step, w_sub_step, w_gen, w_hs, w_last;

    assign w_gen      = (r_state == ST_GEN);
    assign w_hs       = (r_state == ST_HOLD) && rk_ready;
    assign w_last     = (r_round == 4'(NR));
    assign w_expand   = (r_i >= 6'(NK));
    assign w_rot_step = w_expand && (r_imod == 3'd0);
    assign w_sub_step = w_expand && (NK == 8) && (r_imod == 3'd4);

    // r_win[0] is w[i-Nk], r_win[NK-1] is w[i-1]; during the first Nk steps the
    // window simply rotates so the key words come out in order.
    assign w_temp   = r_win[NK-1];
    assign w_sub_in = (r_imod == 3'd0) ? {w_temp[23:0], w_temp[31:24]} : w_temp;

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .i_byte(w_sub_in[8*b +: 8]),
            .o_byte(w_sub_out[8*b +: 8])
        );
    end

    always_comb begin
        w_mixed = w_temp;
        if (w_rot_step) begin
            w_mixed = w_sub_out ^ {r_rcon, 24'h0};
        end else if (w_sub_step) begin
            w_mixed = w_sub_out;
        end
    end

    assign w_word = w_expand ? (r_win[0] ^ w_mixed) : r_win[0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_GEN;
            ST_GEN:  if (r_i[1:0] == 2'b11) w_next = ST_HOLD;
            ST_HOLD: if (rk_ready) w_next = w_last ? ST_IDLE : ST_GEN;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int j = 0; j < NK; j++) r_win[j] <= '0;
            r_asm   <= '0;
            r_i     <= '0;
            r_imod  <= '0;
            r_rcon  <= 8'h01;
            r_round <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_hs && w_last;
            if (r_state == ST_IDLE && start) begin
                for (int j = 0; j < NK; j++) r_win[j] <= key[KEY_BITS-1-32*j -: 32];
                r_i     <= '0;
                r_imod  <= '0;
                r_rcon  <= 8'h01;
                r_round <= '0;
            end else if (w_gen) begin
                for (int j = 0; j < NK-1; j++) r_win[j] <= r_win[j+1];
                r_win[NK-1] <= w_word;
                r_asm       <= {r_asm[11:0], w_word};
                r_i         <= r_i + 6'd1;
                r_imod      <= (r_imod == 3'(NK-1)) ? 3'd0 : r_imod + 3'd1;
                if (w_rot_step) r_rcon <= xtime(r_rcon);
            end else if (w_hs && !w_last) begin
                r_round <= r_round + 4'd1;
            end
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign rk_valid = (r_state == ST_HOLD);
    assign rk       = r_asm;
    assign rk_index = r_round;
    assign done     = r_done;

endmodule

// File: tb/tb_aes_key_schedule.sv
// tb/tb_aes_key_schedule.sv - self-checking bench for aes_key_schedule (128/192/256 instances)
module tb_aes_key_schedule;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic         start_a    [3];
    logic         rk_ready_a [3];
    logic         busy_a     [3];
    logic         rk_valid_a [3];
    logic         done_a     [3];
    logic [127:0] rk_a       [3];
    logic [3:0]   rk_index_a [3];
    logic [127:0] key128;
    logic [191:0] key192;
    logic [255:0] key256;

    int           n_checks;
    int           n_errors;
    logic [31:0]  exp_w  [60];
    logic [127:0] got_rk [15];
    int           got_n;

    aes_key_schedule #(.KEY_BITS(128)) u_dut128 (
        .clk(clk), .reset_n(reset_n), .start(start_a[0]), .key(key128),
        .busy(busy_a[0]), .rk_valid(rk_valid_a[0]), .rk_ready(rk_ready_a[0]),
        .rk(rk_a[0]), .rk_index(rk_index_a[0]), .done(done_a[0]));

    aes_key_schedule #(.KEY_BITS(192)) u_dut192 (
        .clk(clk), .reset_n(reset_n), .start(start_a[1]), .key(key192),
        .busy(busy_a[1]), .rk_valid(rk_valid_a[1]), .rk_ready(rk_ready_a[1]),
        .rk(rk_a[1]), .rk_index(rk_index_a[1]), .done(done_a[1]));

    aes_key_schedule #(.KEY_BITS(256)) u_dut256 (
        .clk(clk), .reset_n(reset_n), .start(start_a[2]), .key(key256),
        .busy(busy_a[2]), .rk_valid(rk_valid_a[2]), .rk_ready(rk_ready_a[2]),
        .rk(rk_a[2]), .rk_index(rk_index_a[2]), .done(done_a[2]));

    // Reference model: S-box from the field inverse plus affine map, then FIPS-197 expansion.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_m(input logic [7:0] b);
        logic [7:0] inv;
        logic [7:0] s;
        inv = 8'h00;
        if (b != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, b);
        end
        s = 8'h63;
        for (int k = 0; k < 5; k++) s = s ^ ((inv << k) | (inv >> (8 - k)));
        return s;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_m(w[31:24]), sbox_m(w[23:16]), sbox_m(w[15:8]), sbox_m(w[7:0])};
    endfunction

    task automatic build_model(input logic [255:0] k, input int nk);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 60; i++) begin
            if (i < nk) begin
                exp_w[i] = k[255-32*i -: 32];
            end else begin
                t = exp_w[i-1];
                if (i % nk == 0) begin
                    t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = gmul(rc, 8'h02);
                end else if (nk == 8 && i % nk == 4) begin
                    t = sub_word(t);
                end
                exp_w[i] = exp_w[i-nk] ^ t;
            end
        end
    endtask

    function automatic logic [255:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Caller is just past a negedge; returns on the negedge where done is expected.
    task automatic run(input int d, input logic [255:0] k, input bit rnd, input bit poke,
                       input string name);
        int           nr;
        int           cyc;
        int           exp_r;
        bit           last_hs;
        bit           stop;
        logic [127:0] exp_rk;
        nr = 10 + 2 * d;
        build_model(k, 4 + 2 * d);
        key128 = k[255:128];
        key192 = k[255:64];
        key256 = k;
        start_a[d]    = 1'b1;
        rk_ready_a[d] = 1'b1;
        @(negedge clk);
        start_a[d] = 1'b0;
        cyc = 0; exp_r = 0; last_hs = 0; stop = 0; got_n = 0;
        while (!stop) begin
            @(negedge clk);
            cyc++;
            if (last_hs) begin
                n_checks++;
                if (done_a[d] !== 1'b1 || busy_a[d] !== 1'b0 || rk_valid_a[d] !== 1'b0) begin
                    n_errors++;
                    $display("FAIL %s done_cycle: done=%b busy=%b rk_valid=%b, want 1/0/0",
                             name, done_a[d], busy_a[d], rk_valid_a[d]);
                end
                if (!rnd) begin
                    n_checks++;
                    if (cyc != 5 * (nr + 1)) begin
                        n_errors++;
                        $display("FAIL %s length: done at cycle %0d, want %0d", name, cyc, 5 * (nr + 1));
                    end
                end
                stop = 1;
            end else if (cyc > 3000) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s timeout: %0d keys accepted, want %0d", name, exp_r, nr + 1);
                stop = 1;
            end else begin
                if (cyc == 1) begin
                    n_checks++;
                    if (busy_a[d] !== 1'b1 || done_a[d] !== 1'b0) begin
                        n_errors++;
                        $display("FAIL %s busy_after_start: busy=%b done=%b, want 1/0",
                                 name, busy_a[d], done_a[d]);
                    end
                end
                if (!rnd) begin
                    n_checks++;
                    if (rk_valid_a[d] !== (cyc % 5 == 4)) begin
                        n_errors++;
                        $display("FAIL %s valid_timing: cycle %0d rk_valid=%b, want %b",
                                 name, cyc, rk_valid_a[d], (cyc % 5 == 4));
                    end
                end
                rk_ready_a[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                start_a[d]    = poke && (cyc == 7);
                if (poke && cyc == 7) begin
                    key128 = ~k[255:128];
                    key192 = ~k[255:64];
                    key256 = ~k;
                end
                if (rk_valid_a[d] === 1'b1) begin
                    exp_rk = {exp_w[4*exp_r], exp_w[4*exp_r+1], exp_w[4*exp_r+2], exp_w[4*exp_r+3]};
                    n_checks++;
                    if (rk_a[d] !== exp_rk || rk_index_a[d] !== 4'(exp_r)) begin
                        n_errors++;
                        $display("FAIL %s round_key: cycle %0d rk=%h idx=%0d, want rk=%h idx=%0d",
                                 name, cyc, rk_a[d], rk_index_a[d], exp_rk, exp_r);
                    end
                    if (rk_ready_a[d]) begin
                        got_rk[exp_r] = rk_a[d];
                        got_n++;
                        if (exp_r == nr) last_hs = 1;
                        else exp_r++;
                    end
                end
            end
        end
        start_a[d]    = 1'b0;
        rk_ready_a[d] = 1'b0;
    endtask

    task automatic check_idle_outputs(input string name);
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (busy_a[d] !== 1'b0 || rk_valid_a[d] !== 1'b0 || rk_a[d] !== 128'h0 ||
                rk_index_a[d] !== 4'h0 || done_a[d] !== 1'b0) begin
                n_errors++;
                $display("FAIL %s dut%0d: busy=%b valid=%b rk=%h idx=%0d done=%b, want all zero",
                         name, d, busy_a[d], rk_valid_a[d], rk_a[d], rk_index_a[d], done_a[d]);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset_state");
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_aes128_vectors();
        run(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 0, 0, "aes128_fips");
        n_checks++;
        if (got_rk[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            n_errors++;
            $display("FAIL aes128_fips_rk1: got %h want a0fafe1788542cb123a339392a6c7605", got_rk[1]);
        end
        n_checks++;
        if (got_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            n_errors++;
            $display("FAIL aes128_fips_rk10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", got_rk[10]);
        end
    endtask

    task automatic test_aes128_zero();
        run(0, 256'h0, 0, 0, "aes128_zero");
        n_checks++;
        if (got_rk[1] !== 128'h62636363626363636263636362636363 ||
            got_rk[2] !== 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa) begin
            n_errors++;
            $display("FAIL aes128_zero_rk12: got %h %h", got_rk[1], got_rk[2]);
        end
    endtask

    task automatic test_aes192();
        run(1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 0, 0, "aes192");
        n_checks++;
        if (got_rk[0] !== 128'h8e73b0f7da0e6452c810f32b809079e5 ||
            got_rk[1] !== 128'h62f8ead2522c6b7bfe0c91f72402f5a5 || got_n != 13) begin
            n_errors++;
            $display("FAIL aes192_vectors: rk0=%h rk1=%h keys=%0d, want 13 keys", got_rk[0], got_rk[1], got_n);
        end
    endtask

    task automatic test_aes256();
        run(2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 0, 0, "aes256");
        n_checks++;
        if (got_rk[2] !== 128'h9ba354118e6925afa51a8b5f2067fcde || got_rk[3][127:96] !== 32'ha8b09c1a) begin
            n_errors++;
            $display("FAIL aes256_vectors: rk2=%h rk3=%h", got_rk[2], got_rk[3]);
        end
    endtask

    task automatic test_random_backpressure();
        for (int d = 0; d < 3; d++) begin
            run(d, rand_key(), 1, 1, "random_backpressure");
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        for (int d = 0; d < 3; d++) begin
            run(d, rand_key(), 0, 0, "b2b_first");
            run(d, rand_key(), 0, 0, "b2b_second");
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_gen();
        bit found;
        bit done_seen;
        bit busy_seen;
        key128        = rand_key() >> 128;
        start_a[0]    = 1'b1;
        rk_ready_a[0] = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0;
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (busy_a[0] === 1'b1 && rk_valid_a[0] === 1'b0 && rk_index_a[0] === 4'd3) found = 1;
        end
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL reset_mid_find_gen3: never saw GEN of rk_index 3, want it within 200 cycles");
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check_idle_outputs("reset_mid_gen");
        done_seen = 0;
        busy_seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (done_a[0] !== 1'b0) done_seen = 1;
            if (busy_a[0] !== 1'b0) busy_seen = 1;
        end
        n_checks++;
        if (done_seen || busy_seen) begin
            n_errors++;
            $display("FAIL reset_mid_quiet: done_seen=%b busy_seen=%b, want 0/0", done_seen, busy_seen);
        end
        run(0, rand_key(), 0, 0, "after_reset");
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        key128   = '0;
        key192   = '0;
        key256   = '0;
        for (int d = 0; d < 3; d++) begin
            start_a[d]    = 1'b0;
            rk_ready_a[d] = 1'b0;
        end
        test_reset();
        test_aes128_vectors();
        test_aes128_zero();
        test_aes192();
        test_aes256();
        test_random_backpressure();
        test_back_to_back();
        test_reset_mid_gen();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Sequential, parametrised AES round-key generator supporting AES-128, AES-192 and AES-256. It replaces the single-round combinational key expansion step with an iterative engine. The engine produces one 32-bit schedule word per cycle and hands out the Nr+1 128-bit round keys through a valid/ready stream. It sits between the key register and the cipher round datapath, and the cipher consumes round keys in order.

## Interface
- KEY_BITS, 128, key length; legal values 128, 192, 256 (Nk = KEY_BITS/32; Nr = 10/12/14).
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  reset, synchronous and active-low.
- start  in  1  request a new expansion; accepted only in IDLE.
- key  in  KEY_BITS  cipher key, sampled on an accepted start; key[KEY_BITS-1 -: 8] is key byte 0 (FIPS-197 order).
- busy  out  1  high in GEN and HOLD.
- rk_valid  out  1  round key on rk is valid.
- rk_ready  in  1  consumer accepts rk this cycle.
- rk  out  128  round key; rk[127:96] = w[4r], rk[31:0] = w[4r+3].
- rk_index  out  4  round number r of rk, 0..Nr.
- done  out  1  one-cycle pulse after the last round key is accepted.

## Operation
- FSM states: IDLE, GEN, HOLD.
- **IDLE**
  - On start, load the key into the Nk-word window, set word index i=0, set rcon=0x01, set r=0, and go to GEN.
  - start is ignored in GEN and HOLD.
- **GEN**: each cycle, compute w[i], shift it into the 4-word assembly register, and increment i.
  - For i < Nk: w[i] = key word i.
  - Otherwise, with temp = w[i-1]:
    - If i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon = xtime(rcon) (0x80 -> 0x1b).
    - Else, if Nk == 8 and i mod Nk == 4: temp = SubWord(temp).
    - Then w[i] = w[i-Nk] ^ temp.
  - The window is a shift register of the last Nk words.
  - After the 4th word of a round key, go to HOLD with rk_valid=1.
- **HOLD**
  - rk, rk_index and rk_valid stay stable until rk_valid && rk_ready.
  - On that handshake: if r == Nr, go to IDLE and pulse done. Otherwise increment r and return to GEN.
- rk_ready while rk_valid=0 has no effect.
- Arithmetic: all XORs are bytewise GF(2). xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 0). The i counter is 6 bits (max 59). Nk/Nr are elaborated from KEY_BITS.
- Illegal KEY_BITS: elaboration-time error (assertion); no runtime behaviour is defined.
- Reset mid-operation: FSM returns to IDLE, and the partially generated schedule is discarded with no done pulse.

## Timing
- Reset values: busy=0, rk_valid=0, rk=0, rk_index=0, done=0, FSM=IDLE.
- start accepted at edge T: busy=1 from T+1, and first rk_valid at T+4, rk_index=0.
- Each round key takes 4 GEN cycles plus ≥1 HOLD cycle. With rk_ready tied high, keys are spaced exactly 5 cycles apart.
- A full expansion with ready high takes 5·(Nr+1) cycles: AES-128 = 55, AES-192 = 65, AES-256 = 75.
- done is high for the single cycle after the final handshake edge, with busy=0 and rk_valid=0 in that cycle.
- start is accepted in the same cycle done is high; back-to-back expansions have no dead cycle beyond that.
- Backpressure stalls only in HOLD; no word is generated while rk_valid && !rk_ready.

## Structure
- Package aes_pkg:
  - aes_word_t (logic [31:0]) and aes_rk_t (logic [15:0][7:0]);
  - nk/nr functions of KEY_BITS;
  - xtime function;
  - FSM state enum.
- Sub-module aes_sbox: a combinational byte S-box. Four instances form SubWord; they are shared by the RotWord and plain SubWord paths via a mux.
- Window register sized Nk (max 8 words); unused entries are elaborated away.

## Test plan
- AES-128 key 2b7e1516 28aed2a6 abf71588 09cf4f3c, rk_ready=1 -> rk_index 1 = a0fafe17 88542cb1 23a33939 2a6c7605; rk_index 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6; done at cycle 55.
- AES-128 all-zero key -> rk_index 1 = 62636363 62636363 62636363 62636363; rk_index 2 = 9b9898c9 f9fbfbaa 9b9898c9 f9fbfbaa.
- AES-192 key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b -> rk_index 0 = the first 4 key words; rk_index 1 begins 62f8ead2 522c6b7b fe0c91f7 2402f5a5; 13 keys total.
- AES-256 key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 -> rk_index 2 = 9ba35411 8e6925af a51a8b5f 2067fcde; rk_index 3 begins a8b09c1a (SubWord-only path).
- rk_ready driven by a random pattern, plus a start pulse while busy -> rk/rk_index held stable while stalled; the same key sequence as the ready-high run; the mid-run start is ignored.
- reset_n low for 1 cycle during GEN of rk_index 3 -> all outputs reach their reset values at the next edge; no done pulse; a subsequent start produces a correct full schedule.
